chime_ctrl: RTL and testbench
=============================

CHIME_CTRL -- requirements
Module: chime_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line: BURST_ALARM, 4, beeps per alarm burst; ALARM_SECS, 60, alarm ring duration in seconds; WDOG_SECS, 15, maximum seconds to wait for buzz_done.
REQ-002 The block SHALL have ports, one per line: clk  input  1  single system clock, all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 tick_1s  input  1  one-cycle pulse marking a seconds update; time inputs are valid in that cycle.
REQ-005 hour_bcd  input  8  current hour, BCD 00-23; min_bcd  input  8  minute, BCD 00-59; sec_bcd  input  8  second, BCD 00-59.
REQ-006 chime_en  input  1  enables the hourly chime; alarm_en  input  1  enables the alarm.
REQ-007 alarm_hour  input  8  alarm hour, BCD; alarm_min  input  8  alarm minute, BCD.
REQ-008 stop  input  1  one-cycle pulse that silences an active alarm.
REQ-009 buzz_done  input  1  one-cycle pulse from the beep engine when a requested burst has finished.
REQ-010 beep_start  output  1  one-cycle request pulse to the beep engine.
REQ-011 beep_count  output  5  number of beeps in the request, valid and held from beep_start until the next beep_start.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 alarm_active  output  1  high while an alarm ring period is in progress.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT and GAP, with transitions START->WAIT after one cycle, WAIT->IDLE or GAP on buzz_done, and GAP->START on tick_1s.
REQ-015 The chime trigger SHALL fire in a tick_1s cycle with chime_en=1, min_bcd=8'h00 and sec_bcd=8'h00.
REQ-016 The alarm trigger SHALL fire in a tick_1s cycle with alarm_en=1, hour_bcd=alarm_hour, min_bcd=alarm_min and sec_bcd=8'h00.
REQ-017 The chime count SHALL be the hour in 12-hour form: 00->12, 01-12 unchanged, 13-23 minus 12, converted from BCD to 5-bit binary (1..12).
REQ-018 The alarm count SHALL be BURST_ALARM, truncated to 5 bits.
REQ-019 In IDLE, a trigger SHALL load beep_count and move to START; START SHALL assert beep_start for exactly one cycle; the response latency from the tick_1s cycle to beep_start SHALL be 1 cycle.
REQ-020 When alarm and chime trigger in the same cycle, the alarm SHALL win and the chime SHALL be discarded.
REQ-021 An alarm trigger during a chime SHALL set a pending flag; on the chime's buzz_done, the FSM SHALL go to START with the alarm count, with no gap.
REQ-022 A chime trigger while busy SHALL be discarded.
REQ-023 On alarm trigger, alarm_active SHALL rise and a seconds counter SHALL clear; the counter SHALL increment on each tick_1s while alarm_active is high.
REQ-024 In an alarm, buzz_done SHALL go to GAP while alarm_active=1 and to IDLE otherwise; GAP SHALL re-issue beep_start on the next tick_1s.
REQ-025 alarm_active SHALL clear when the counter reaches ALARM_SECS or on stop; a burst in flight SHALL complete and then the FSM SHALL return to IDLE.
REQ-026 stop in GAP SHALL return the FSM to IDLE on the next edge; stop outside an alarm SHALL be ignored.
REQ-027 In WAIT, a watchdog SHALL count tick_1s; reaching WDOG_SECS SHALL force IDLE, clearing alarm_active and pending.
REQ-028 buzz_done outside WAIT SHALL be ignored.

Reset
REQ-029 rst low SHALL immediately force IDLE, with beep_start=0, beep_count=0, busy=0, alarm_active=0, pending=0 and all counters=0, including mid-burst; no beep_start SHALL be emitted on release.

Verification
REQ-030 Chime: tick_1s at 15:00:00 with chime_en=1 -> beep_start one cycle later, beep_count=3, busy held until buzz_done; at 00:00:00 -> beep_count=12.
REQ-031 Alarm: alarm 07:30, tick at 07:30:00 -> beep_count=4, alarm_active=1; buzz_done each second -> one beep_start per tick until 60 s elapse, then IDLE.
REQ-032 Stop: stop during WAIT -> alarm_active=0 at once, no further beep_start, IDLE after buzz_done; stop during GAP -> IDLE next cycle.
REQ-033 Collision: alarm 12:00 with chime_en=1 at 12:00:00 -> single request with beep_count=4; alarm at 13:00 raised during an active chime -> alarm beep_start in the cycle after the chime's buzz_done.
REQ-034 Watchdog: beep_start issued, buzz_done withheld for 15 ticks -> IDLE, busy=0, alarm_active=0.
REQ-035 Reset: rst pulsed low in WAIT -> all outputs 0 asynchronously; no beep_start after release until the next trigger.

Source files
------------

// File: rtl/chime_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  chime_ctrl_if : request/completion handshake to the beep engine
//  Revision 1.0
// ============================================================================
interface chime_ctrl_if;
    logic       beep_start;
    logic [4:0] beep_count;
    logic       buzz_done;

    modport master (output beep_start, output beep_count, input buzz_done);
    modport slave  (input beep_start, input beep_count, output buzz_done);
endinterface
`default_nettype wire

// File: rtl/chime_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  chime_ctrl : hourly chime and alarm sequencer driving a beep engine
//  Revision 1.0
// ============================================================================
module chime_ctrl #(
    parameter int BURST_ALARM = 4,
    parameter int ALARM_SECS  = 60,
    parameter int WDOG_SECS   = 15
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       tick_1s,
    input  wire logic [7:0] hour_bcd,
    input  wire logic [7:0] min_bcd,
    input  wire logic [7:0] sec_bcd,
    input  wire logic       chime_en,
    input  wire logic       alarm_en,
    input  wire logic [7:0] alarm_hour,
    input  wire logic [7:0] alarm_min,
    input  wire logic       stop,
    chime_ctrl_if.master    beep,
    output logic            busy,
    output logic            alarm_active
);

    localparam int         AW          = $clog2(ALARM_SECS + 1);
    localparam int         WW          = $clog2(WDOG_SECS + 1);
    localparam logic [4:0] ALARM_COUNT = 5'(BURST_ALARM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [4:0]    count_q;
    logic [AW-1:0] alarm_secs;
    logic [WW-1:0] wd_cnt;
    logic          pending;

    logic [4:0]    hour_bin;
    logic [4:0]    chime_count;
    logic          chime_trig;
    logic          alarm_trig;
    logic          stop_hit;
    logic          expire;
    logic          alarm_hold;
    logic          wd_fire;
    logic          load;
    logic [4:0]    load_val;
    logic          take_pending;

    always_comb begin
        hour_bin = 5'(hour_bcd[5:4]) * 5'd10 + 5'(hour_bcd[3:0]);
        if (hour_bin == 5'd0)
            chime_count = 5'd12;
        else if (hour_bin > 5'd12)
            chime_count = hour_bin - 5'd12;
        else
            chime_count = hour_bin;
    end

    assign chime_trig = tick_1s & chime_en & (min_bcd == 8'h00) & (sec_bcd == 8'h00);
    assign alarm_trig = tick_1s & alarm_en & (hour_bcd == alarm_hour)
                      & (min_bcd == alarm_min) & (sec_bcd == 8'h00);
    assign stop_hit   = stop & alarm_active;
    assign expire     = tick_1s & alarm_active & (alarm_secs == AW'(ALARM_SECS - 1));
    // Whether the alarm ring period is still running after this edge
    assign alarm_hold = alarm_trig | (alarm_active & ~stop & ~expire);
    assign wd_fire    = (state == WAIT) & tick_1s & ~beep.buzz_done
                      & (wd_cnt == WW'(WDOG_SECS - 1));

    always_comb begin
        state_next   = state;
        load         = 1'b0;
        load_val     = chime_count;
        take_pending = 1'b0;
        case (state)
            IDLE: begin
                if (alarm_trig) begin
                    state_next = START;
                    load       = 1'b1;
                    load_val   = ALARM_COUNT;
                end else if (chime_trig) begin
                    state_next = START;
                    load       = 1'b1;
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (beep.buzz_done) begin
                    if (pending && alarm_hold) begin
                        state_next   = START;
                        load         = 1'b1;
                        load_val     = ALARM_COUNT;
                        take_pending = 1'b1;
                    end else if (alarm_hold) begin
                        state_next = GAP;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (wd_fire) begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (!alarm_hold)
                    state_next = IDLE;
                else if (tick_1s)
                    state_next = START;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q      <= 5'd0;
            alarm_active <= 1'b0;
            alarm_secs   <= '0;
            wd_cnt       <= '0;
            pending      <= 1'b0;
        end else begin
            if (load)
                count_q <= load_val;

            if (state != WAIT)
                wd_cnt <= '0;
            else if (tick_1s)
                wd_cnt <= wd_cnt + WW'(1);

            if (take_pending)
                pending <= 1'b0;

            // A watchdog abort outranks everything, including a fresh alarm
            if (wd_fire || stop_hit) begin
                alarm_active <= 1'b0;
                pending      <= 1'b0;
            end else if (alarm_trig) begin
                alarm_active <= 1'b1;
                alarm_secs   <= '0;
                if ((state == START || state == WAIT) && !alarm_active)
                    pending <= 1'b1;
            end else if (alarm_active && tick_1s) begin
                alarm_secs <= alarm_secs + AW'(1);
                if (expire)
                    alarm_active <= 1'b0;
            end
        end
    end

    assign beep.beep_start = (state == START);
    assign beep.beep_count = count_q;
    assign busy            = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_chime_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_chime_ctrl : directed vectors with a seconds-level behavioural model
//  Revision 1.0
// ============================================================================
module tb_chime_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1s = 1'b0;
    logic [7:0] hour_bcd = 8'h00;
    logic [7:0] min_bcd = 8'h00;
    logic [7:0] sec_bcd = 8'h01;
    logic       chime_en = 1'b0;
    logic       alarm_en = 1'b0;
    logic [7:0] alarm_hour = 8'h07;
    logic [7:0] alarm_min = 8'h30;
    logic       stop = 1'b0;
    logic       busy;
    logic       alarm_active;

    chime_ctrl_if bif ();

    chime_ctrl #(.BURST_ALARM(4), .ALARM_SECS(60), .WDOG_SECS(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1s      (tick_1s),
        .hour_bcd     (hour_bcd),
        .min_bcd      (min_bcd),
        .sec_bcd      (sec_bcd),
        .chime_en     (chime_en),
        .alarm_en     (alarm_en),
        .alarm_hour   (alarm_hour),
        .alarm_min    (alarm_min),
        .stop         (stop),
        .beep         (bif),
        .busy         (busy),
        .alarm_active (alarm_active)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    int s0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: seconds left in the ring, burst outstanding, waiting for the next second
    bit m_req, m_inflight, m_wait_tick, m_queued;
    int m_ring, m_dog, m_cnt;

    function automatic int hour12(input logic [7:0] h);
        int b;
        b = int'(h[7:4]) * 10 + int'(h[3:0]);
        if (b == 0) return 12;
        if (b > 12) return b - 12;
        return b;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        bit prev_req, chime, alarm, in_wait, done;
        if (!rst) begin
            m_req = 0; m_inflight = 0; m_wait_tick = 0; m_queued = 0;
            m_ring = 0; m_dog = 0; m_cnt = 0;
        end else begin
            prev_req = m_req;
            m_req    = 0;
            chime = tick_1s && chime_en && min_bcd == 8'h00 && sec_bcd == 8'h00;
            alarm = tick_1s && alarm_en && hour_bcd == alarm_hour
                    && min_bcd == alarm_min && sec_bcd == 8'h00;
            if (!m_inflight && !m_wait_tick) begin
                if (alarm) begin
                    m_ring = 60; m_req = 1; m_cnt = 4; m_inflight = 1; m_dog = 0;
                end else if (chime) begin
                    m_req = 1; m_cnt = hour12(hour_bcd); m_inflight = 1; m_dog = 0;
                end
            end else begin
                in_wait = m_inflight && !prev_req;
                done    = in_wait && bif.buzz_done;
                if (alarm) begin
                    if (m_inflight && m_ring == 0) m_queued = 1;
                    m_ring = 60;
                end else if (stop && m_ring > 0) begin
                    m_ring = 0; m_queued = 0;
                end else if (tick_1s && m_ring > 0) begin
                    m_ring--;
                end
                if (done) begin
                    m_inflight = 0;
                    if (m_queued) begin
                        m_queued = 0; m_req = 1; m_cnt = 4; m_inflight = 1; m_dog = 0;
                    end else if (m_ring > 0) begin
                        m_wait_tick = 1;
                    end
                end else if (in_wait && tick_1s) begin
                    m_dog++;
                    if (m_dog == 15) begin
                        m_inflight = 0; m_ring = 0; m_queued = 0;
                    end
                end else if (m_wait_tick) begin
                    if (m_ring == 0) m_wait_tick = 0;
                    else if (tick_1s) begin
                        m_wait_tick = 0; m_req = 1; m_inflight = 1; m_dog = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("beep_start", bif.beep_start, m_req);
            check("beep_count", bif.beep_count, m_cnt);
            check("busy", busy, m_inflight || m_wait_tick);
            check("alarm_active", alarm_active, m_ring > 0);
            if (bif.beep_start) starts++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1s = 1'b1; step(); tick_1s = 1'b0;
    endtask

    task automatic pulse_done();
        bif.buzz_done = 1'b1; step(); bif.buzz_done = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        hour_bcd = h; min_bcd = m; sec_bcd = s;
    endtask

    initial begin
        bif.buzz_done = 1'b0;
        #12;
        check("reset_beep_start", bif.beep_start, 0);
        check("reset_busy", busy, 0);
        check("reset_alarm_active", alarm_active, 0);
        check("reset_beep_count", bif.beep_count, 0);
        step();
        rst = 1'b1;
        repeat (2) step();

        // Chime at 15:00:00
        chime_en = 1'b1;
        set_time(8'h15, 8'h00, 8'h00);
        pulse_tick();
        check("chime15_start", bif.beep_start, 1);
        check("chime15_count", bif.beep_count, 3);
        sec_bcd = 8'h01;
        step();
        check("chime15_pulse_width", bif.beep_start, 0);
        check("chime15_busy_held", busy, 1);
        repeat (3) step();
        pulse_done();
        check("chime15_idle", busy, 0);
        check("chime15_count_held", bif.beep_count, 3);

        // Chime at midnight
        set_time(8'h00, 8'h00, 8'h00);
        pulse_tick();
        check("chime00_count", bif.beep_count, 12);
        sec_bcd = 8'h01;
        step();
        pulse_done();

        // No chime when disabled or off the hour
        chime_en = 1'b0;
        set_time(8'h01, 8'h00, 8'h00);
        pulse_tick();
        check("chime_disabled", busy, 0);
        chime_en = 1'b1;
        set_time(8'h13, 8'h00, 8'h01);
        pulse_tick();
        check("chime_sec_nonzero", busy, 0);
        pulse_done();
        check("done_in_idle", busy, 0);

        // Full alarm ring at 07:30
        chime_en = 1'b0;
        alarm_en = 1'b1;
        alarm_hour = 8'h07; alarm_min = 8'h30;
        set_time(8'h07, 8'h30, 8'h00);
        s0 = starts;
        pulse_tick();
        check("alarm_count", bif.beep_count, 4);
        check("alarm_active_rise", alarm_active, 1);
        sec_bcd = 8'h01;
        for (int k = 1; k <= 60; k++) begin
            repeat (2) step();
            pulse_done();
            repeat (2) step();
            pulse_tick();
        end
        step();
        check("alarm_total_starts", starts - s0, 60);
        check("alarm_end_idle", busy, 0);
        check("alarm_end_inactive", alarm_active, 0);

        // Stop during WAIT
        sec_bcd = 8'h00;
        pulse_tick();
        sec_bcd = 8'h01;
        step();
        pulse_stop();
        check("stopwait_alarm_off", alarm_active, 0);
        check("stopwait_busy", busy, 1);
        s0 = starts;
        pulse_tick();
        step();
        pulse_done();
        check("stopwait_idle", busy, 0);
        check("stopwait_no_start", starts - s0, 0);

        // Stop during GAP
        sec_bcd = 8'h00;
        pulse_tick();
        sec_bcd = 8'h01;
        step();
        pulse_done();
        check("stopgap_in_gap", busy, 1);
        pulse_stop();
        check("stopgap_idle", busy, 0);
        check("stopgap_alarm_off", alarm_active, 0);

        // Alarm and chime at 12:00:00 together
        chime_en = 1'b1;
        alarm_hour = 8'h12; alarm_min = 8'h00;
        set_time(8'h12, 8'h00, 8'h00);
        s0 = starts;
        pulse_tick();
        check("collide_count", bif.beep_count, 4);
        sec_bcd = 8'h01;
        pulse_stop();
        step();
        pulse_done();
        check("collide_single", starts - s0, 1);
        check("collide_idle", busy, 0);

        // 13:00 alarm raised while the 13:00 chime is in flight
        alarm_en = 1'b0;
        set_time(8'h13, 8'h00, 8'h00);
        pulse_tick();
        check("pend_chime_count", bif.beep_count, 1);
        step();
        alarm_en = 1'b1;
        alarm_hour = 8'h13;
        pulse_tick();
        check("pend_alarm_active", alarm_active, 1);
        check("pend_no_start", bif.beep_start, 0);
        sec_bcd = 8'h01;
        step();
        pulse_done();
        check("pend_start", bif.beep_start, 1);
        check("pend_count", bif.beep_count, 4);
        pulse_stop();
        step();
        pulse_done();
        check("pend_idle", busy, 0);

        // Watchdog: buzz_done withheld
        chime_en = 1'b0;
        alarm_hour = 8'h07; alarm_min = 8'h30;
        set_time(8'h07, 8'h30, 8'h00);
        pulse_tick();
        sec_bcd = 8'h01;
        step();
        repeat (14) begin
            pulse_tick();
            step();
        end
        check("wdog_still_busy", busy, 1);
        pulse_tick();
        check("wdog_idle", busy, 0);
        check("wdog_alarm_off", alarm_active, 0);

        // Asynchronous reset in WAIT
        alarm_en = 1'b0;
        chime_en = 1'b1;
        set_time(8'h15, 8'h00, 8'h00);
        pulse_tick();
        sec_bcd = 8'h01;
        step();
        #2 rst = 1'b0;
        #1;
        check("rst_beep_start", bif.beep_start, 0);
        check("rst_busy", busy, 0);
        check("rst_beep_count", bif.beep_count, 0);
        check("rst_alarm_active", alarm_active, 0);
        step();
        rst = 1'b1;
        s0 = starts;
        repeat (10) step();
        pulse_done();
        check("rst_no_start", starts - s0, 0);
        check("rst_idle", busy, 0);
        sec_bcd = 8'h00;
        pulse_tick();
        check("rst_retrigger_count", bif.beep_count, 3);
        sec_bcd = 8'h01;
        step();
        pulse_done();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
